// File: rtl/cond_ctrl_pipe_pkg.sv
// ============================================================================
// Module   : cond_ctrl_pipe_pkg
// Purpose  : Shared condition codes, flag bit positions and control bundles
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cond_ctrl_pipe_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_t;

  localparam int c_FLAG_N = 3;
  localparam int c_FLAG_Z = 2;
  localparam int c_FLAG_C = 1;
  localparam int c_FLAG_V = 0;

  // Decode-to-execute control bundle
  typedef struct packed {
    logic       pcsrc;
    logic       regwrite;
    logic       memwrite;
    logic       memtoreg;
    logic       branch;
    logic [1:0] flagwrite;
    logic [3:0] cond;
  } ctrl_t;

  // Controls that survive past execute
  typedef struct packed {
    logic pcsrc;
    logic regwrite;
    logic memwrite;
    logic memtoreg;
  } mctl_t;

endpackage

`default_nettype wire

// File: rtl/cond_ctrl_pipe_cond_check.sv
// ============================================================================
// Module   : cond_check
// Purpose  : Combinational ARM condition-code evaluation against {N,Z,C,V}
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_check
  import cond_ctrl_pipe_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_pass
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = i_flags[c_FLAG_N];
  assign w_z = i_flags[c_FLAG_Z];
  assign w_c = i_flags[c_FLAG_C];
  assign w_v = i_flags[c_FLAG_V];

  always_comb begin
    o_pass = 1'b0;
    case (i_cond)
      COND_EQ: o_pass = w_z;
      COND_NE: o_pass = ~w_z;
      COND_CS: o_pass = w_c;
      COND_CC: o_pass = ~w_c;
      COND_MI: o_pass = w_n;
      COND_PL: o_pass = ~w_n;
      COND_VS: o_pass = w_v;
      COND_VC: o_pass = ~w_v;
      COND_HI: o_pass = w_c & ~w_z;
      COND_LS: o_pass = ~w_c | w_z;
      COND_GE: o_pass = (w_n == w_v);
      COND_LT: o_pass = (w_n != w_v);
      COND_GT: o_pass = ~w_z & (w_n == w_v);
      COND_LE: o_pass = w_z | (w_n != w_v);
      COND_AL: o_pass = 1'b1;
      default: o_pass = 1'b0;  // 0xF never executes
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/cond_ctrl_pipe.sv
// ============================================================================
// Module   : cond_ctrl_pipe
// Purpose  : Conditional-execution control pipeline D->E->M(xN)->W with flags
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_ctrl_pipe
  import cond_ctrl_pipe_pkg::*;
#(
  parameter int CTRL_W     = 8,
  parameter int MEM_STAGES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_d,
  input  logic              pcsrc_d,
  input  logic              regwrite_d,
  input  logic              memwrite_d,
  input  logic              memtoreg_d,
  input  logic              branch_d,
  input  logic [1:0]        flagwrite_d,
  input  logic [3:0]        cond_d,
  input  logic [CTRL_W-1:0] side_d,
  input  logic [3:0]        alu_flags_e,
  input  logic              stall_e,
  input  logic              flush_e,
  output logic              condex_e,
  output logic              branch_taken_e,
  output logic              carry_e,
  output logic [3:0]        flags_q,
  output logic              pcsrc_e,
  output logic              pcsrc_m,
  output logic              pcsrc_w,
  output logic              regwrite_m,
  output logic              regwrite_w,
  output logic              memwrite_m,
  output logic              memtoreg_e,
  output logic              memtoreg_w,
  output logic [CTRL_W-1:0] side_e,
  output logic [CTRL_W-1:0] side_w
);

  logic              r_valid_e;
  ctrl_t             r_ctrl_e;
  logic [CTRL_W-1:0] r_side_e;
  logic [3:0]        r_flags;
  logic              w_pass;
  logic              w_condex;
  ctrl_t             w_ctrl_d;

  mctl_t [MEM_STAGES:0]             w_m_chain;
  logic  [MEM_STAGES:0][CTRL_W-1:0] w_side_chain;

  mctl_t             r_ctrl_w;
  logic [CTRL_W-1:0] r_side_w;

  assign w_ctrl_d = '{pcsrc: pcsrc_d, regwrite: regwrite_d, memwrite: memwrite_d,
                      memtoreg: memtoreg_d, branch: branch_d,
                      flagwrite: flagwrite_d, cond: cond_d};

  // Flush beats stall so a squashed slot can never be held
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid_e <= 1'b0;
      r_ctrl_e  <= '0;
      r_side_e  <= '0;
    end else if (flush_e) begin
      r_valid_e <= 1'b0;
      r_ctrl_e  <= '0;
      r_side_e  <= '0;
    end else if (!stall_e) begin
      r_valid_e <= valid_d;
      r_ctrl_e  <= w_ctrl_d;
      r_side_e  <= side_d;
    end
  end

  cond_check u_cond_check (
    .i_cond  (r_ctrl_e.cond),
    .i_flags (r_flags),
    .o_pass  (w_pass)
  );

  assign w_condex = r_valid_e & w_pass;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags <= '0;
    end else begin
      if (w_condex && r_ctrl_e.flagwrite[1] && !stall_e) begin
        r_flags[c_FLAG_N] <= alu_flags_e[c_FLAG_N];
        r_flags[c_FLAG_Z] <= alu_flags_e[c_FLAG_Z];
      end
      if (w_condex && r_ctrl_e.flagwrite[0] && !stall_e) begin
        r_flags[c_FLAG_C] <= alu_flags_e[c_FLAG_C];
        r_flags[c_FLAG_V] <= alu_flags_e[c_FLAG_V];
      end
    end
  end

  // A stalled E instruction stays put, so M sees a bubble
  always_comb begin
    w_m_chain[0]    = '0;
    w_side_chain[0] = '0;
    if (!stall_e) begin
      w_m_chain[0].pcsrc    = r_ctrl_e.pcsrc    & w_condex;
      w_m_chain[0].regwrite = r_ctrl_e.regwrite & w_condex;
      w_m_chain[0].memwrite = r_ctrl_e.memwrite & w_condex;
      w_m_chain[0].memtoreg = r_ctrl_e.memtoreg;
      w_side_chain[0]       = r_side_e;
    end
  end

  for (genvar gi = 0; gi < MEM_STAGES; gi++) begin : g_mem_stage
    mctl_t             r_ctrl_m;
    logic [CTRL_W-1:0] r_side_m;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_ctrl_m <= '0;
        r_side_m <= '0;
      end else begin
        r_ctrl_m <= w_m_chain[gi];
        r_side_m <= w_side_chain[gi];
      end
    end

    assign w_m_chain[gi+1]    = r_ctrl_m;
    assign w_side_chain[gi+1] = r_side_m;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl_w <= '0;
      r_side_w <= '0;
    end else begin
      r_ctrl_w <= w_m_chain[MEM_STAGES];
      r_side_w <= w_side_chain[MEM_STAGES];
    end
  end

  assign condex_e       = w_condex;
  assign branch_taken_e = r_ctrl_e.branch & w_condex;
  assign carry_e        = r_flags[c_FLAG_C];
  assign flags_q        = r_flags;
  assign pcsrc_e        = r_ctrl_e.pcsrc;
  assign memtoreg_e     = r_ctrl_e.memtoreg;
  assign side_e         = r_side_e;
  assign pcsrc_m        = w_m_chain[MEM_STAGES].pcsrc;
  assign regwrite_m     = w_m_chain[MEM_STAGES].regwrite;
  assign memwrite_m     = w_m_chain[MEM_STAGES].memwrite;
  assign pcsrc_w        = r_ctrl_w.pcsrc;
  assign regwrite_w     = r_ctrl_w.regwrite;
  assign memtoreg_w     = r_ctrl_w.memtoreg;
  assign side_w         = r_side_w;

endmodule

`default_nettype wire

// File: tb/tb_cond_ctrl_pipe.sv
// ============================================================================
// Module   : tb_cond_ctrl_pipe
// Purpose  : Directed self-checking bench for cond_ctrl_pipe (MEM_STAGES=2)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cond_ctrl_pipe;

  localparam int CTRL_W     = 8;
  localparam int MEM_STAGES = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              valid_d, pcsrc_d, regwrite_d, memwrite_d, memtoreg_d, branch_d;
  logic [1:0]        flagwrite_d;
  logic [3:0]        cond_d;
  logic [CTRL_W-1:0] side_d;
  logic [3:0]        alu_flags_e;
  logic              stall_e, flush_e;
  logic              condex_e, branch_taken_e, carry_e;
  logic [3:0]        flags_q;
  logic              pcsrc_e, pcsrc_m, pcsrc_w, regwrite_m, regwrite_w;
  logic              memwrite_m, memtoreg_e, memtoreg_w;
  logic [CTRL_W-1:0] side_e, side_w;

  int n_vec = 0;
  int n_miscmp = 0;

  always #5 clk = ~clk;

  cond_ctrl_pipe #(.CTRL_W(CTRL_W), .MEM_STAGES(MEM_STAGES)) dut (
    .clk(clk), .reset(reset), .valid_d(valid_d), .pcsrc_d(pcsrc_d),
    .regwrite_d(regwrite_d), .memwrite_d(memwrite_d), .memtoreg_d(memtoreg_d),
    .branch_d(branch_d), .flagwrite_d(flagwrite_d), .cond_d(cond_d),
    .side_d(side_d), .alu_flags_e(alu_flags_e), .stall_e(stall_e),
    .flush_e(flush_e), .condex_e(condex_e), .branch_taken_e(branch_taken_e),
    .carry_e(carry_e), .flags_q(flags_q), .pcsrc_e(pcsrc_e), .pcsrc_m(pcsrc_m),
    .pcsrc_w(pcsrc_w), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .memwrite_m(memwrite_m), .memtoreg_e(memtoreg_e), .memtoreg_w(memtoreg_w),
    .side_e(side_e), .side_w(side_w)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miscmp++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic v, input logic [3:0] c, input logic rw, input logic mw,
                       input logic mtr, input logic br, input logic [1:0] fw,
                       input logic [CTRL_W-1:0] sd);
    valid_d     = v;
    cond_d      = c;
    regwrite_d  = rw;
    memwrite_d  = mw;
    memtoreg_d  = mtr;
    branch_d    = br;
    pcsrc_d     = 1'b0;
    flagwrite_d = fw;
    side_d      = sd;
  endtask

  task automatic idle_d();
    set_d(1'b0, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, '0);
  endtask

  initial begin
    reset = 1'b1; stall_e = 1'b0; flush_e = 1'b0; alu_flags_e = 4'h0;
    idle_d();
    #1;
    tick(); tick();
    chk("rst_flags", 32'(flags_q), 32'h0);
    chk("rst_condex", 32'(condex_e), 32'h0);
    chk("rst_side_e", 32'(side_e), 32'h0);
    chk("rst_rw_w", 32'(regwrite_w), 32'h0);
    reset = 1'b0;

    // Single AL regwrite reaches W four edges later, one cycle wide
    set_d(1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'hA5);
    tick();
    chk("lat_condex", 32'(condex_e), 32'h1);
    chk("lat_side_e", 32'(side_e), 32'hA5);
    idle_d();
    tick();
    chk("lat_rw_w_e2", 32'(regwrite_w), 32'h0);
    tick();
    chk("lat_rw_m_e3", 32'(regwrite_m), 32'h1);
    chk("lat_rw_w_e3", 32'(regwrite_w), 32'h0);
    tick();
    chk("lat_rw_w_e4", 32'(regwrite_w), 32'h1);
    chk("lat_side_w", 32'(side_w), 32'hA5);
    tick();
    chk("lat_rw_w_e5", 32'(regwrite_w), 32'h0);

    // CMP sets N, following MI branch is taken
    set_d(1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, '0);
    tick();
    alu_flags_e = 4'b1000;
    set_d(1'b1, 4'h4, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, '0);
    tick();
    chk("cmp_flags", 32'(flags_q), 32'h8);
    chk("mi_taken", 32'(branch_taken_e), 32'h1);
    chk("mi_carry", 32'(carry_e), 32'h0);
    alu_flags_e = 4'h0;

    // Z=1: NE store squashed, EQ store performed
    set_d(1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, '0);
    tick();
    chk("br_not_taken_al_cmp", 32'(branch_taken_e), 32'h0);
    alu_flags_e = 4'b0100;
    set_d(1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, '0);
    tick();
    chk("z_flags", 32'(flags_q), 32'h4);
    chk("ne_condex", 32'(condex_e), 32'h0);
    alu_flags_e = 4'h0;
    set_d(1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, '0);
    tick();
    chk("eq_condex", 32'(condex_e), 32'h1);
    idle_d();
    tick();
    chk("ne_memwrite_m", 32'(memwrite_m), 32'h0);
    tick();
    chk("eq_memwrite_m", 32'(memwrite_m), 32'h1);

    // C,V-only write keeps Z; then a few condition codes against 0110
    set_d(1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, '0);
    tick();
    alu_flags_e = 4'b0010;
    set_d(1'b1, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, '0);
    tick();
    chk("cv_flags", 32'(flags_q), 32'h6);
    chk("cv_carry", 32'(carry_e), 32'h1);
    chk("hi_condex", 32'(condex_e), 32'h0);
    alu_flags_e = 4'b1111;
    set_d(1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, '0);
    tick();
    chk("ls_condex", 32'(condex_e), 32'h1);
    set_d(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, '0);
    tick();
    chk("ne_fw_condex", 32'(condex_e), 32'h0);
    set_d(1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, '0);
    tick();
    chk("ne_fw_blocked", 32'(flags_q), 32'h6);
    chk("ge_condex", 32'(condex_e), 32'h1);
    set_d(1'b1, 4'hD, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, '0);
    tick();
    chk("le_condex", 32'(condex_e), 32'h1);
    alu_flags_e = 4'h0;

    // cond 0xF never executes; memtoreg still flows
    set_d(1'b1, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, '0);
    tick();
    chk("nv_condex", 32'(condex_e), 32'h0);
    idle_d();
    tick();
    tick();
    chk("nv_rw_m", 32'(regwrite_m), 32'h0);
    tick();
    chk("nv_rw_w", 32'(regwrite_w), 32'h0);
    chk("nv_mtr_w", 32'(memtoreg_w), 32'h1);

    // Two-cycle stall with regwrite + N,Z write in E
    set_d(1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 8'h3C);
    tick();
    idle_d();
    stall_e = 1'b1;
    alu_flags_e = 4'b1000;
    tick();
    chk("stl_a_flags", 32'(flags_q), 32'h6);
    chk("stl_a_condex", 32'(condex_e), 32'h1);
    chk("stl_a_side_e", 32'(side_e), 32'h3C);
    tick();
    chk("stl_b_flags", 32'(flags_q), 32'h6);
    chk("stl_b_rw_m", 32'(regwrite_m), 32'h0);
    stall_e = 1'b0;
    tick();
    chk("stl_c_flags", 32'(flags_q), 32'hA);
    chk("stl_c_rw_m", 32'(regwrite_m), 32'h0);
    alu_flags_e = 4'h0;
    tick();
    chk("stl_d_rw_m", 32'(regwrite_m), 32'h1);
    chk("stl_d_rw_w", 32'(regwrite_w), 32'h0);
    chk("stl_d_flags", 32'(flags_q), 32'hA);
    tick();
    chk("stl_e_rw_w", 32'(regwrite_w), 32'h1);
    chk("stl_e_side_w", 32'(side_w), 32'h3C);
    chk("stl_e_rw_m", 32'(regwrite_m), 32'h0);
    tick();
    chk("stl_f_rw_w", 32'(regwrite_w), 32'h0);

    // Flush with a flag-writing instruction leaving E
    set_d(1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, '0);
    tick();
    alu_flags_e = 4'b0001;
    flush_e = 1'b1;
    set_d(1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h77);
    tick();
    chk("fl_flags", 32'(flags_q), 32'h1);
    chk("fl_condex", 32'(condex_e), 32'h0);
    chk("fl_side_e", 32'(side_e), 32'h0);
    flush_e = 1'b0;
    idle_d();
    alu_flags_e = 4'h0;
    tick();
    chk("fl_rw_m", 32'(regwrite_m), 32'h1);
    tick();
    chk("fl_rw_w", 32'(regwrite_w), 32'h1);
    chk("fl_rw_m_bub", 32'(regwrite_m), 32'h0);
    tick();
    chk("fl_rw_w_bub", 32'(regwrite_w), 32'h0);

    // Stall and flush together: flush wins
    set_d(1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h11);
    tick();
    chk("sf_pre_condex", 32'(condex_e), 32'h1);
    idle_d();
    stall_e = 1'b1;
    flush_e = 1'b1;
    tick();
    chk("sf_condex", 32'(condex_e), 32'h0);
    chk("sf_side_e", 32'(side_e), 32'h0);
    stall_e = 1'b0;
    flush_e = 1'b0;
    tick();
    tick();
    chk("sf_rw_m", 32'(regwrite_m), 32'h0);

    // Reset during stall discards the held instruction
    set_d(1'b1, 4'hE, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 8'h55);
    tick();
    idle_d();
    stall_e = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    chk("rs_flags", 32'(flags_q), 32'h0);
    chk("rs_condex", 32'(condex_e), 32'h0);
    chk("rs_taken", 32'(branch_taken_e), 32'h0);
    chk("rs_side_e", 32'(side_e), 32'h0);
    chk("rs_rw_m", 32'(regwrite_m), 32'h0);
    chk("rs_rw_w", 32'(regwrite_w), 32'h0);
    reset = 1'b0;
    stall_e = 1'b0;
    tick(); tick(); tick();
    chk("rs_rw_w_after", 32'(regwrite_w), 32'h0);
    chk("rs_mw_m_after", 32'(memwrite_m), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

`default_nettype wire
